// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into instruction memory at consecutive addresses,
// stalls the core until the program is complete, and reports a word count and XOR checksum.
module imem_loader #(
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter int START_ADDR = 0,
    parameter int RUN_DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam int DLY_W = $clog2(RUN_DELAY + 1);

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_RUN, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               cpu_run_q, cpu_run_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [31:0]        sum_q, sum_d;
    logic               xfer;

    assign load_ready = (state_q == S_LOAD);
    assign xfer       = load_valid & load_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        dly_d       = dly_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_run_d   = cpu_run_q;
        done_d      = done_q;
        err_d       = err_q;
        count_d     = count_q;
        sum_d       = sum_q;

        // reload wins over everything, including a coincident transfer
        if (reload) begin
            state_d   = S_LOAD;
            ptr_d     = ADDR_W'(START_ADDR);
            dly_d     = '0;
            cpu_run_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            count_d   = '0;
            sum_d     = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = load_data;
                        ptr_d       = ptr_q + 1'b1;
                        count_d     = count_q + 1'b1;
                        sum_d       = sum_q ^ load_data;
                        if (load_last) begin
                            state_d = S_DRAIN;
                            dly_d   = '0;
                        end else if (count_d == (ADDR_W+1)'(DEPTH)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // the extra count lets the final write land before the first fetch
                    if (dly_q == DLY_W'(RUN_DELAY)) begin
                        state_d   = S_RUN;
                        cpu_run_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            ptr_q       <= ADDR_W'(START_ADDR);
            dly_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_run_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            dly_q       <= dly_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_run    = cpu_run_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = count_q;
    assign checksum   = sum_q;

endmodule
